step_counter: RTL

STEP_COUNTER -- requirements
Module: step_counter

---
 rtl/step_counter_pkg.sv | 16 +
 rtl/inc_addsub.sv | 27 ++
 rtl/step_counter.sv | 99 +++++++++
 3 files changed

// File: rtl/step_counter_pkg.sv
// Shared definitions for the counter family: mode encodings and a mode decoder.
package step_counter_pkg;

    typedef enum logic {
        WRAP     = 1'b0,
        SATURATE = 1'b1
    } count_mode_e;

    localparam int MODE_WRAP     = 0;
    localparam int MODE_SATURATE = 1;

    function automatic logic mode_is_saturate(input int mode);
        return (mode == int'(SATURATE));
    endfunction

endpackage

// File: rtl/inc_addsub.sv
// Combinational WIDTH-bit adder/subtractor; Co is the carry (add) or borrow (subtract).
module inc_addsub #(
    parameter int WIDTH = 4
) (
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             SUB,
    output logic [WIDTH-1:0] S,
    output logic             Co
);

    logic [WIDTH:0] w_res;

    // Zero-extended arithmetic so the top bit is carry on add and borrow on subtract.
    always_comb begin
        w_res = {(WIDTH+1){1'b0}};
        if (SUB) begin
            w_res = {1'b0, A} - {1'b0, B};
        end else begin
            w_res = {1'b0, A} + {1'b0, B};
        end
    end

    assign S  = w_res[WIDTH-1:0];
    assign Co = w_res[WIDTH];

endmodule

// File: rtl/step_counter.sv
// Loadable up/down counter with programmable step, wrap or saturate on overflow.
module step_counter
    import step_counter_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter int SAT   = MODE_WRAP
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             LD,
    input  logic [WIDTH-1:0] D,
    input  logic             EN,
    input  logic             DN,
    input  logic [WIDTH-1:0] STEP,
    output logic [WIDTH-1:0] Q,
    output logic             Co,
    output logic             SATD
);

    localparam logic L_SAT = mode_is_saturate(SAT);

    logic [WIDTH-1:0] r_q;
    logic             r_co;
    logic             r_satd;

    logic [WIDTH-1:0] w_sum;
    logic             w_ovf;
    logic             w_step_zero;
    logic [WIDTH-1:0] w_q_nxt;
    logic             w_co_nxt;
    logic             w_satd_nxt;

    inc_addsub #(
        .WIDTH (WIDTH)
    ) u_addsub (
        .A   (r_q),
        .B   (STEP),
        .SUB (DN),
        .S   (w_sum),
        .Co  (w_ovf)
    );

    assign w_step_zero = (STEP == {WIDTH{1'b0}});

    // Next-state selection: load beats enable; in saturate mode a step that
    // overflows while already pinned at the limit produces no new Co pulse.
    always_comb begin
        w_q_nxt    = r_q;
        w_co_nxt   = 1'b0;
        w_satd_nxt = r_satd;
        if (LD) begin
            w_q_nxt    = D;
            w_co_nxt   = 1'b0;
            w_satd_nxt = 1'b0;
        end else if (EN) begin
            if (L_SAT) begin
                if (w_ovf) begin
                    w_q_nxt    = DN ? {WIDTH{1'b0}} : {WIDTH{1'b1}};
                    w_co_nxt   = ~r_satd;
                    w_satd_nxt = 1'b1;
                end else if (w_step_zero) begin
                    w_q_nxt    = r_q;
                    w_co_nxt   = 1'b0;
                    w_satd_nxt = r_satd;
                end else begin
                    w_q_nxt    = w_sum;
                    w_co_nxt   = 1'b0;
                    w_satd_nxt = 1'b0;
                end
            end else begin
                w_q_nxt    = w_sum;
                w_co_nxt   = w_ovf;
                w_satd_nxt = 1'b0;
            end
        end else begin
            w_q_nxt    = r_q;
            w_co_nxt   = 1'b0;
            w_satd_nxt = r_satd;
        end
    end

    // All counter state lives here.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_q    <= {WIDTH{1'b0}};
            r_co   <= 1'b0;
            r_satd <= 1'b0;
        end else begin
            r_q    <= w_q_nxt;
            r_co   <= w_co_nxt;
            r_satd <= w_satd_nxt;
        end
    end

    assign Q    = r_q;
    assign Co   = r_co;
    assign SATD = r_satd;

endmodule
